fb_word_writer: RTL and testbench

Write-side stage of the on-chip frame buffer (OCM). It sits directly downstream of the background loader and consumes its `writing` / `addr_OCM` / 16-bit data handshake. Each captured 16-bit SRAM word becomes two sequential byte writes into the 8-bit single-port frame-buffer memory, and the block answers the loader with `OCM_done`. The VGA scan-out read always has priority on the shared memory port; loader writes stall while the display is reading.

---
 rtl/fb_word_writer.sv | 95 +++++++++
 tb/tb_fb_word_writer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_word_writer.sv
// rtl/fb_word_writer.sv - frame-buffer write stage: 16-bit loader word to two byte writes, display has priority
module fb_word_writer #(
    parameter int FB_BYTES        = 307200,
    parameter int ADDR_W          = 19,
    parameter bit HIGH_BYTE_FIRST = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              writing,
    input  logic [ADDR_W-1:0] addr_OCM,
    input  logic [15:0]       data_in,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic              clr_count,
    output logic              OCM_done,
    output logic              busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              overflow_err,
    output logic [ADDR_W-1:0] bytes_written
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WR0  = 2'd1;
    localparam logic [1:0] WR1  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // One extra bit so FB_BYTES == 2**ADDR_W is still representable
    localparam logic [ADDR_W:0] FB_LIMIT = (ADDR_W+1)'(FB_BYTES);

    logic [1:0]        state;
    logic [ADDR_W-1:0] base;
    logic [15:0]       word;

    logic              in_wr;
    logic              wr_active;
    logic              in_range;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        first_byte;
    logic [7:0]        second_byte;
    logic [7:0]        wr_byte;

    assign in_wr       = (state == WR0) || (state == WR1);
    assign wr_active   = in_wr && !vid_req;
    assign wr_addr     = (state == WR1) ? base + ADDR_W'(1) : base;
    assign in_range    = ({1'b0, wr_addr} < FB_LIMIT);
    assign first_byte  = HIGH_BYTE_FIRST ? word[15:8] : word[7:0];
    assign second_byte = HIGH_BYTE_FIRST ? word[7:0]  : word[15:8];
    assign wr_byte     = (state == WR1) ? second_byte : first_byte;

    assign mem_we    = wr_active && in_range;
    assign mem_addr  = vid_req ? vid_addr : (in_wr ? wr_addr : '0);
    assign mem_wdata = wr_active ? wr_byte : 8'd0;
    assign OCM_done  = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            base  <= '0;
            word  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (writing) begin
                        base  <= addr_OCM;
                        word  <= data_in;
                        state <= WR0;
                    end
                end
                WR0:     if (!vid_req) state <= WR1;
                WR1:     if (!vid_req) state <= DONE;
                // Holding here until writing drops stops a still-high request from being captured twice
                DONE:    if (!writing) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            overflow_err  <= 1'b0;
            bytes_written <= '0;
        end else begin
            if (wr_active && !in_range)
                overflow_err <= 1'b1;
            if (clr_count)
                bytes_written <= '0;
            else if (mem_we)
                bytes_written <= bytes_written + ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_fb_word_writer.sv
// tb/tb_fb_word_writer.sv - self-checking bench for fb_word_writer
module tb_fb_word_writer;

    localparam int FB = 307200;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        writing;
    logic [18:0] addr_OCM;
    logic [15:0] data_in;
    logic        vid_req;
    logic [18:0] vid_addr;
    logic        clr_count;
    logic        OCM_done;
    logic        busy;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        overflow_err;
    logic [18:0] bytes_written;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    fb_word_writer #(.FB_BYTES(FB), .ADDR_W(19), .HIGH_BYTE_FIRST(1'b1)) dut (
        .Clk(Clk), .Reset(Reset), .writing(writing), .addr_OCM(addr_OCM),
        .data_in(data_in), .vid_req(vid_req), .vid_addr(vid_addr),
        .clr_count(clr_count), .OCM_done(OCM_done), .busy(busy),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .overflow_err(overflow_err), .bytes_written(bytes_written)
    );

    typedef struct {
        logic        wr;
        logic [18:0] addr;
        logic [15:0] data;
        logic        vid;
        logic [18:0] vaddr;
        logic        clr;
        logic        e_we;
        logic [18:0] e_addr;
        logic [7:0]  e_wd;
        logic        e_done;
        logic        e_busy;
        logic [18:0] e_bw;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(logic wr, logic [18:0] addr, logic [15:0] data, logic vid,
                                logic [18:0] vaddr, logic clr, logic e_we, logic [18:0] e_addr,
                                logic [7:0] e_wd, logic e_done, logic e_busy, logic [18:0] e_bw);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.vid = vid; v.vaddr = vaddr; v.clr = clr;
        v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd; v.e_done = e_done;
        v.e_busy = e_busy; v.e_bw = e_bw;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [18:0] a, input logic [15:0] d,
                         input logic v, input logic [18:0] va, input logic c);
        writing = wr; addr_OCM = a; data_in = d; vid_req = v; vid_addr = va; clr_count = c;
        #2;
    endtask

    // reference model state for the randomized phase
    logic [18:0] m_bw;
    logic        m_ovf;
    logic [18:0] qa[2];
    logic [7:0]  qd[2];

    initial begin
        logic [18:0] a;
        logic [15:0] d;
        logic        v;
        logic [18:0] va;
        logic        c;
        logic        inr;
        int          mode;
        int          idx;
        int          cyc;
        int          hold;

        vecs[0]  = mk(1, 19'h00100, 16'hABCD, 0, 19'h0,     0, 0, 19'h0,     8'h00, 0, 0, 19'd0);
        vecs[1]  = mk(1, 19'h00000, 16'h5555, 0, 19'h0,     0, 1, 19'h00100, 8'hAB, 0, 1, 19'd0);
        vecs[2]  = mk(1, 19'h00000, 16'h5555, 0, 19'h0,     0, 1, 19'h00101, 8'hCD, 0, 1, 19'd1);
        vecs[3]  = mk(1, 19'h00000, 16'h0000, 0, 19'h0,     0, 0, 19'h0,     8'h00, 1, 1, 19'd2);
        vecs[4]  = mk(0, 19'h00000, 16'h0000, 0, 19'h0,     0, 0, 19'h0,     8'h00, 1, 1, 19'd2);
        vecs[5]  = mk(0, 19'h00000, 16'h0000, 0, 19'h0,     0, 0, 19'h0,     8'h00, 0, 0, 19'd2);
        vecs[6]  = mk(1, 19'h00200, 16'h1234, 0, 19'h0,     0, 0, 19'h0,     8'h00, 0, 0, 19'd2);
        vecs[7]  = mk(1, 19'h00000, 16'h0000, 1, 19'h12345, 0, 0, 19'h12345, 8'h00, 0, 1, 19'd2);
        vecs[8]  = mk(1, 19'h00000, 16'h0000, 1, 19'h12345, 0, 0, 19'h12345, 8'h00, 0, 1, 19'd2);
        vecs[9]  = mk(1, 19'h00000, 16'h0000, 1, 19'h12345, 0, 0, 19'h12345, 8'h00, 0, 1, 19'd2);
        vecs[10] = mk(1, 19'h00000, 16'h0000, 0, 19'h0,     0, 1, 19'h00200, 8'h12, 0, 1, 19'd2);
        vecs[11] = mk(1, 19'h00000, 16'h0000, 0, 19'h0,     0, 1, 19'h00201, 8'h34, 0, 1, 19'd3);
        vecs[12] = mk(0, 19'h00000, 16'h0000, 0, 19'h0,     0, 0, 19'h0,     8'h00, 1, 1, 19'd4);
        vecs[13] = mk(0, 19'h00000, 16'h0000, 1, 19'h7FFFF, 0, 0, 19'h7FFFF, 8'h00, 0, 0, 19'd4);

        Reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        #2;
        chk("reset_done", OCM_done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_we", mem_we, 0);
        chk("reset_addr", mem_addr, 0);
        chk("reset_wdata", mem_wdata, 0);
        chk("reset_ovf", overflow_err, 0);
        chk("reset_bw", bytes_written, 0);
        tick();

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].vid, vecs[i].vaddr, vecs[i].clr);
            chk($sformatf("vec%0d_we", i), mem_we, vecs[i].e_we);
            chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].e_wd);
            chk($sformatf("vec%0d_done", i), OCM_done, vecs[i].e_done);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d_bw", i), bytes_written, vecs[i].e_bw);
            tick();
        end

        // range boundary: last legal byte, then one past the end
        drive(1, 19'(FB - 1), 16'h1122, 0, 0, 1);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        chk("rng_we0", mem_we, 1);
        chk("rng_addr0", mem_addr, FB - 1);
        chk("rng_wd0", mem_wdata, 8'h11);
        chk("rng_ovf_pre", overflow_err, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        chk("rng_we1", mem_we, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        chk("rng_done", OCM_done, 1);
        chk("rng_ovf", overflow_err, 1);
        chk("rng_bw", bytes_written, 1);
        tick();

        // handshake hold: writing kept high after done
        for (int h = 0; h < 5; h++) begin
            drive(1, 19'h00055, 16'h9999, 0, 0, 0);
            chk($sformatf("hold%0d_done", h), OCM_done, 1);
            chk($sformatf("hold%0d_we", h), mem_we, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("drop_done", OCM_done, 1);
        tick();
        drive(1, 19'h00010, 16'hBEEF, 0, 0, 0);
        chk("drop_idle_busy", busy, 0);
        chk("drop_idle_done", OCM_done, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        chk("recap_we", mem_we, 1);
        chk("recap_addr", mem_addr, 19'h00010);
        chk("recap_wd", mem_wdata, 8'hBE);
        tick();

        // reset during WR1
        drive(1, 0, 0, 0, 0, 0);
        chk("rst_wr1_addr", mem_addr, 19'h00011);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk("rst_done", OCM_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_bw", bytes_written, 0);
        tick();

        // clear colliding with the second byte write
        drive(1, 19'h00040, 16'h6789, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        chk("clr_we0", mem_we, 1);
        tick();
        drive(1, 0, 0, 0, 0, 1);
        chk("clr_bw_mid", bytes_written, 1);
        chk("clr_we1", mem_we, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("clr_done", OCM_done, 1);
        chk("clr_bw", bytes_written, 0);
        tick();

        // randomized transactions against a byte-list model
        m_bw  = 19'd0;
        m_ovf = 1'b0;
        for (int t = 0; t < 40; t++) begin
            mode = $urandom_range(2, 0);
            if (mode == 0)      a = 19'($urandom_range(FB - 3, 0));
            else if (mode == 1) a = 19'($urandom_range(FB + 1, FB - 2));
            else                a = 19'h7FFFF - 19'($urandom_range(1, 0));
            d = 16'($urandom);
            qa[0] = a;
            qa[1] = a + 19'd1;
            qd[0] = d[15:8];
            qd[1] = d[7:0];

            v  = ($urandom_range(2, 0) == 0);
            va = 19'($urandom);
            c  = ($urandom_range(7, 0) == 0);
            drive(1, a, d, v, va, c);
            chk("rnd_cap_busy", busy, 0);
            chk("rnd_cap_we", mem_we, 0);
            chk("rnd_cap_addr", mem_addr, v ? va : 19'd0);
            tick();
            if (c) m_bw = 19'd0;

            idx = 0;
            cyc = 0;
            while (idx < 2 && cyc < 200) begin
                v  = ($urandom_range(2, 0) == 0);
                va = 19'($urandom);
                c  = ($urandom_range(7, 0) == 0);
                drive($urandom_range(1, 0) == 1, 19'($urandom), 16'($urandom), v, va, c);
                inr = (int'(qa[idx]) < FB);
                chk("rnd_busy", busy, 1);
                chk("rnd_done", OCM_done, 0);
                chk("rnd_ovf", overflow_err, m_ovf);
                chk("rnd_bw", bytes_written, m_bw);
                if (v) begin
                    chk("rnd_stall_we", mem_we, 0);
                    chk("rnd_stall_addr", mem_addr, va);
                end else begin
                    chk("rnd_we", mem_we, inr);
                    chk("rnd_addr", mem_addr, qa[idx]);
                    if (inr) chk("rnd_wdata", mem_wdata, qd[idx]);
                end
                tick();
                if (c) m_bw = 19'd0;
                else if (!v && inr) m_bw = m_bw + 19'd1;
                if (!v && !inr) m_ovf = 1'b1;
                if (!v) idx++;
                cyc++;
            end
            if (idx < 2) begin
                checks++;
                errors++;
                $display("FAIL rnd_timeout: bytes issued %0d expected 2", idx);
            end

            hold = $urandom_range(2, 0);
            for (int h = 0; h <= hold; h++) begin
                v  = ($urandom_range(2, 0) == 0);
                va = 19'($urandom);
                drive(h < hold, 19'($urandom), 16'($urandom), v, va, 0);
                chk("rnd_dn_done", OCM_done, 1);
                chk("rnd_dn_we", mem_we, 0);
                chk("rnd_dn_addr", mem_addr, v ? va : 19'd0);
                chk("rnd_dn_ovf", overflow_err, m_ovf);
                chk("rnd_dn_bw", bytes_written, m_bw);
                tick();
            end
            drive(0, 0, 0, 0, 0, 0);
            chk("rnd_idle_busy", busy, 0);
            chk("rnd_idle_done", OCM_done, 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
